// File: rtl/stall_ctrl_pkg.sv
// Shared types and legacy constants for the pipeline stall/flush controller.
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_GSTALL = 2'd1,
    ST_HOLD   = 2'd2
  } stall_state_e;

  // Encoding compatible with the old fixed four-level, five-stage encoder.
  localparam int unsigned DefNumStages  = 5;
  localparam int unsigned StallLevelLen = $clog2(DefNumStages + 1);

  localparam logic [StallLevelLen-1:0] Stall_Null   = StallLevelLen'(0);
  localparam logic [StallLevelLen-1:0] Stall_Decode = StallLevelLen'(1);
  localparam logic [StallLevelLen-1:0] Stall_Issue  = StallLevelLen'(2);
  localparam logic [StallLevelLen-1:0] Stall_All    = StallLevelLen'(DefNumStages);

endpackage

// File: rtl/stall_prio_enc.sv
// Highest-set-bit encoder: index of the top request, a valid flag and the
// thermometer mask covering bits 0..index.
module stall_prio_enc #(
  parameter int unsigned NumBits = 5,
  parameter int unsigned IdxW    = 3
) (
  input  logic [NumBits-1:0] req_i,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o,
  output logic [NumBits-1:0] therm_o
);

  logic acc;

  always_comb begin
    acc     = 1'b0;
    idx_o   = '0;
    therm_o = '0;
    for (int i = NumBits - 1; i >= 0; i--) begin
      acc        = acc | req_i[i];
      therm_o[i] = acc;
    end
    for (int i = 0; i < NumBits; i++) begin
      if (req_i[i]) idx_o = IdxW'(i);
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: per-stage stall, bubble and flush masks.
// Define STALL_PERF_EN to build the saturating stall/flush counters.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned LVL_W      = $clog2(NUM_STAGES + 1),
  parameter int unsigned IO_HOLD    = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  io_buffer_full,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  input  logic [LVL_W-1:0]      flush_stage,
  output logic [NUM_STAGES-1:0] stall_mask,
  output logic [NUM_STAGES-1:0] bubble_mask,
  output logic [NUM_STAGES-1:0] flush_mask,
  output logic [LVL_W-1:0]      stall_level,
  output logic                  gstall,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int unsigned HoldW = $clog2(IO_HOLD + 2);

  stall_state_e          state_q;
  logic [HoldW-1:0]      hold_cnt_q;
  logic                  last_io_q;
  logic                  pend_q, pend_d;
  logic [LVL_W-1:0]      pend_stage_q, pend_stage_d;

  logic                  cause, gstall_int;
  logic [LVL_W-1:0]      fstage_sat, req_stage, pend_eff, merged, issue_stage;
  logic [LVL_W-1:0]      stall_idx, flush_idx;
  logic                  stall_valid, flush_valid;
  logic [NUM_STAGES-1:0] stall_therm, flush_onehot, flush_therm;
  logic                  unused_flush_idx;

  assign cause      = ~rdy_in | io_buffer_full;
  assign gstall_int = rst_in | cause | (state_q != ST_RUN);
  assign gstall     = gstall_int;

  // The GSTALL cycle after io_buffer_full falls is the first hold cycle, so
  // HOLD itself lasts IO_HOLD-1 cycles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_RUN;
      hold_cnt_q <= '0;
      last_io_q  <= 1'b0;
    end else begin
      if (cause) last_io_q <= io_buffer_full;
      unique case (state_q)
        ST_RUN: if (cause) state_q <= ST_GSTALL;
        ST_GSTALL: begin
          if (!cause) begin
            if (last_io_q && (IO_HOLD > 1)) begin
              state_q    <= ST_HOLD;
              hold_cnt_q <= HoldW'(IO_HOLD - 1);
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_HOLD: begin
          if (cause) begin
            state_q    <= ST_GSTALL;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q < HoldW'(2)) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q - HoldW'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    fstage_sat   = (flush_stage > LVL_W'(NUM_STAGES)) ? LVL_W'(NUM_STAGES) : flush_stage;
    req_stage    = flush_req ? fstage_sat : '0;
    pend_eff     = pend_q ? pend_stage_q : '0;
    merged       = (req_stage > pend_eff) ? req_stage : pend_eff;
    issue_stage  = gstall_int ? '0 : merged;
    flush_onehot = '0;
    if (issue_stage != '0) begin
      flush_onehot = NUM_STAGES'(1) << (issue_stage - LVL_W'(1));
    end
    pend_d       = pend_q;
    pend_stage_d = pend_stage_q;
    if (!gstall_int) begin
      pend_d       = 1'b0;
      pend_stage_d = '0;
    end else if (flush_req) begin
      pend_d       = 1'b1;
      pend_stage_d = merged;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_q       <= 1'b0;
      pend_stage_q <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_stage_q <= pend_stage_d;
    end
  end

  stall_prio_enc #(
    .NumBits (NUM_STAGES),
    .IdxW    (LVL_W)
  ) u_stall_enc (
    .req_i   (stall_req),
    .idx_o   (stall_idx),
    .valid_o (stall_valid),
    .therm_o (stall_therm)
  );

  stall_prio_enc #(
    .NumBits (NUM_STAGES),
    .IdxW    (LVL_W)
  ) u_flush_enc (
    .req_i   (flush_onehot),
    .idx_o   (flush_idx),
    .valid_o (flush_valid),
    .therm_o (flush_therm)
  );

  assign unused_flush_idx = ^flush_idx;

  always_comb begin
    if (gstall_int) begin
      stall_mask  = '1;
      bubble_mask = '0;
      flush_mask  = '0;
      stall_level = LVL_W'(NUM_STAGES);
    end else begin
      stall_mask  = stall_therm & ~flush_therm;
      bubble_mask = (stall_therm << 1) & ~stall_therm & ~flush_therm;
      flush_mask  = flush_valid ? flush_therm : '0;
      stall_level = stall_valid ? (stall_idx + LVL_W'(1)) : LVL_W'(Stall_Null);
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if ((|stall_mask) && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if ((|flush_mask) && (flush_count_q != '1)) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Parametrised pipeline stall/flush controller; successor to the fixed three-request, four-level stall encoder.
- Takes one stall request per pipeline stage plus global hazards (not ready, IO buffer full) and produces per-stage stall and bubble masks and a compatible encoded stall level.
- Adds sequential behaviour: IO-full hold extension, flush deferral across global stalls, optional performance counters.
- Sits between the pipeline stages and the stage registers; stage 0 is IF, stage NUM_STAGES-1 is the oldest (MEM/WB side).

Parameters:
- NUM_STAGES, 5, number of pipeline stages (>=2).
- LVL_W, $clog2(NUM_STAGES+1), width of the encoded stall level.
- IO_HOLD, 2, extra cycles global stall is held after io_buffer_full deasserts (0 = none).
- CNT_W, 32, performance counter width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global ready; low forces stall of all stages.
- io_buffer_full  input  1  IO buffer full; forces stall of all stages, extended by IO_HOLD.
- stall_req  input  NUM_STAGES  bit i: stage i cannot advance.
- flush_req  input  1  flush request (branch mispredict).
- flush_stage  input  LVL_W  stages 0..flush_stage-1 are squashed; valid with flush_req.
- stall_mask  output  NUM_STAGES  bit i: stage i holds its register.
- bubble_mask  output  NUM_STAGES  bit i: stage i loads a bubble.
- flush_mask  output  NUM_STAGES  bit i: stage i is squashed this cycle.
- stall_level  output  LVL_W  0 = none, k = stages 0..k-1 stalled, NUM_STAGES = all.
- gstall  output  1  global stall active.
- stall_cycles  output  CNT_W  cycles with any stall (perf option).
- flush_count  output  CNT_W  flushes issued (perf option).

Behaviour:
- Reset: clk_in only, synchronous, rst_in active-high.
  - While rst_in is high: state <= RUN, hold_cnt <= 0, pend_flush <= 0, counters <= 0.
  - Outputs during rst_in: stall_mask all-ones, bubble_mask 0, flush_mask 0, stall_level NUM_STAGES, gstall 1.
  - Reset mid-operation discards any pending flush and hold.
- FSM states:
  - RUN: no global stall.
  - GSTALL: rdy_in low or io_buffer_full high.
  - HOLD: io_buffer_full has just deasserted and hold_cnt>0.
- Transitions:
  - RUN/HOLD -> GSTALL when (~rdy_in | io_buffer_full).
  - GSTALL -> HOLD when both are clear, the last cause was io_buffer_full, and IO_HOLD>0; load hold_cnt = IO_HOLD-1.
  - GSTALL -> RUN when both are clear otherwise.
  - HOLD decrements hold_cnt and goes to RUN when hold_cnt==0 and no cause is present.
  - With IO_HOLD=2, gstall stays high for exactly 2 cycles after io_buffer_full falls.
- gstall is combinational: high when (~rdy_in | io_buffer_full | state!=RUN). Same-cycle response, so hazards are never missed.
- Global stall: stall_mask all-ones, bubble_mask 0, stall_level NUM_STAGES, flush_mask 0.
- Local stall, gstall low:
  - h = highest i with stall_req[i]. stall_mask bits 0..h = 1.
  - If h<NUM_STAGES-1, bubble_mask[h+1]=1.
  - stall_level = h+1. No request gives all zeros and level 0.
- Flush:
  - If flush_req and gstall is low: flush_mask bits 0..flush_stage-1 = 1 in the same cycle.
  - Flushed stages have their stall_mask and bubble bits cleared.
  - A stall from a stage >= flush_stage still applies.
- Flush while globally stalled:
  - If flush_req arrives while gstall is high, latch pend_flush=1 and pend_stage=flush_stage. Issue flush_mask on the first cycle gstall is low, then clear.
  - A new flush_req while pending: keep max(pend_stage, flush_stage).
  - A new flush_req in the issue cycle merges the same way (max).
- flush_stage values > NUM_STAGES saturate to NUM_STAGES.

Optional Feature:
- STALL_PERF_EN defined:
  - stall_cycles increments (saturating) on each non-reset cycle with any stall_mask bit set.
  - flush_count increments (saturating) on each cycle flush_mask != 0.
- STALL_PERF_EN undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package/header holds:
  - state encodings ST_RUN, ST_GSTALL, ST_HOLD.
  - legacy level aliases Stall_Null=0, Stall_Decode=1, Stall_Issue=2, Stall_All=NUM_STAGES, in the StallLevelLen-compatible width.
- One sub-module, stall_prio_enc: highest-set-bit encoder producing h, a valid flag, and the thermometer mask; reused for flush-mask generation.

Test Plan:
- rst_in=1 for 3 cycles, then release with all inputs idle:
  - during reset: stall_mask=5'b11111, level=5.
  - after release: stall_mask=0, level=0, gstall=0.
- stall_req=5'b00100 (NUM_STAGES=5) -> stall_mask=5'b00111, bubble_mask=5'b01000, stall_level=3.
- io_buffer_full high for 4 cycles then low, IO_HOLD=2 -> gstall high 4+2=6 cycles. stall_mask all-ones throughout, then RUN.
- flush_req with flush_stage=3 while rdy_in=0 for 2 more cycles:
  - flush_mask=0 while stalled.
  - flush_mask=5'b00111 on the first cycle rdy_in=1, then 0.
  - a second flush_stage=4 during the stall yields 5'b01111.
- Same-cycle flush_stage=2 and stall_req=5'b01001 -> flush_mask=5'b00011, stall_mask=5'b01100, bubble_mask=5'b10000.
- STALL_PERF_EN: 10 stalled cycles and 2 flushes -> stall_cycles=10, flush_count=2. Counter preset to max holds max. Undefined macro -> both read 0.
